gpio_mmio: RTL and testbench

Parametrised memory-mapped GPIO controller. It replaces the fixed 16-bit switch reader and LED driver pair on the CPU I/O bus. It provides `CH_W` switch inputs with synchronisation and debounce, a readable/writable LED register, sticky per-bit edge flags with write-1-to-clear, and a level interrupt. It sits behind the memory/IO address decoder and is selected by the decoder's chip-select.

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_debounce.sv | 53 +++++
 rtl/gpio_mmio.sv | 109 ++++++++++
 tb/tb_gpio_mmio.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO controller: register offsets
// and the debounce counter width helper.
package gpio_pkg;

  typedef enum logic [1:0] {
    GPIO_SW   = 2'd0,
    GPIO_LED  = 2'd1,
    GPIO_EDGE = 2'd2,
    GPIO_IEN  = 2'd3
  } gpio_reg_e;

  localparam int unsigned GPIO_DEBOUNCE_DEFAULT = 20000;
  localparam int unsigned GPIO_CNT_W_DEFAULT    = $clog2(GPIO_DEBOUNCE_DEFAULT);

  // Width of a counter that must hold 0..cyc-1.
  function automatic int unsigned gpio_cnt_w(input int unsigned cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Per-channel synchroniser and two-tick debouncer; reports which stable bits
// change in the current cycle so the parent can latch sticky edge flags.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int CH_W = 16
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            i_tick,
  input  logic [CH_W-1:0] i_switches,
  output logic [CH_W-1:0] o_stable,
  output logic [CH_W-1:0] o_change
);

  logic [CH_W-1:0] r_meta;
  logic [CH_W-1:0] r_sync;
  logic [CH_W-1:0] r_samp;
  logic [CH_W-1:0] r_stable;
  logic [CH_W-1:0] w_agree;
  logic [CH_W-1:0] w_stableNext;

  assign w_agree = ~(r_sync ^ r_samp);

  // A level is accepted only when the sample taken at the previous tick still
  // matches the synchronised input at this tick.
  always_comb begin
    w_stableNext = r_stable;
    if (i_tick) begin
      w_stableNext = (w_agree & r_samp) | (~w_agree & r_stable);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_samp   <= '0;
      r_stable <= '0;
    end else begin
      r_meta   <= i_switches;
      r_sync   <= r_meta;
      if (i_tick) begin
        r_samp <= r_sync;
      end
      r_stable <= w_stableNext;
    end
  end

  assign o_stable = r_stable;
  assign o_change = w_stableNext ^ r_stable;

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO controller: debounced switches, LED register, sticky
// W1C edge flags with per-bit enables, and a registered level interrupt.
module gpio_mmio
  import gpio_pkg::*;
#(
  parameter int CH_W         = 16,
  parameter int DEBOUNCE_CYC = GPIO_DEBOUNCE_DEFAULT
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            cs,
  input  logic            io_read,
  input  logic            io_write,
  input  logic [3:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [CH_W-1:0] switches,
  output logic [CH_W-1:0] leds,
  output logic            irq
);

  localparam int unsigned CNT_W = gpio_cnt_w(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CH_W-1:0]  r_leds;
  logic [CH_W-1:0]  r_ien;
  logic [CH_W-1:0]  r_edgeFlags;
  logic             r_irq;

  logic             w_tick;
  logic             w_wr;
  logic             w_rd;
  gpio_reg_e        w_sel;
  logic [CH_W-1:0]  w_stable;
  logic [CH_W-1:0]  w_change;
  logic [CH_W-1:0]  w_clr;
  logic [CH_W-1:0]  w_wbits;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_tick  = (r_cnt == CNT_LAST);
  assign w_wr    = cs & io_write;
  assign w_rd    = cs & io_read;
  assign w_sel   = gpio_reg_e'(addr[3:2]);
  assign w_wbits = wdata[CH_W-1:0];
  assign w_clr   = (w_wr && (w_sel == GPIO_EDGE)) ? w_wbits : '0;

  assign w_unused = ^{addr[1:0], wdata};

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  gpio_debounce #(
    .CH_W(CH_W)
  ) u_debounce (
    .clock     (clock),
    .rst       (rst),
    .i_tick    (w_tick),
    .i_switches(switches),
    .o_stable  (w_stable),
    .o_change  (w_change)
  );

  // A change arriving in the same cycle as a W1C must not be lost, so the set
  // term is applied after the clear.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_leds      <= '0;
      r_ien       <= '0;
      r_edgeFlags <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr && (w_sel == GPIO_LED)) begin
        r_leds <= w_wbits;
      end
      if (w_wr && (w_sel == GPIO_IEN)) begin
        r_ien <= w_wbits;
      end
      r_edgeFlags <= (r_edgeFlags & ~w_clr) | w_change;
      r_irq       <= |(r_edgeFlags & r_ien);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_sel)
        GPIO_SW:   w_rdata[CH_W-1:0] = w_stable;
        GPIO_LED:  w_rdata[CH_W-1:0] = r_leds;
        GPIO_EDGE: w_rdata[CH_W-1:0] = r_edgeFlags;
        GPIO_IEN:  w_rdata[CH_W-1:0] = r_ien;
        default:   w_rdata = '0;
      endcase
    end
  end

  assign rdata = w_rdata;
  assign leds  = r_leds;
  assign irq   = r_irq;

endmodule

// File: tb/tb_gpio_mmio.sv
// Directed bench for gpio_mmio: register vector table plus hand-timed debounce,
// edge/irq and W1C collision sequences, and a narrow-channel instance.
module tb_gpio_mmio;

  typedef struct {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_leds;
  } vec_t;

  logic        clock = 1'b0;
  logic        rst;
  logic        cs, io_read, io_write;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic [15:0] switches, leds;
  logic        irq;

  logic        cs5, rd5, wr5;
  logic [3:0]  addr5;
  logic [31:0] wdata5, rdata5;
  logic [4:0]  switches5, leds5;
  logic        irq5;

  int   checks = 0;
  int   fails  = 0;
  int   cyc;
  vec_t vecs[15];
  logic [31:0] d;

  always #5 clock = ~clock;

  // Bench-side copy of the debounce counter phase (DEBOUNCE_CYC = 4).
  always @(posedge clock or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  gpio_mmio #(.CH_W(16), .DEBOUNCE_CYC(4)) dut (
    .clock(clock), .rst(rst), .cs(cs), .io_read(io_read), .io_write(io_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .switches(switches),
    .leds(leds), .irq(irq)
  );

  gpio_mmio #(.CH_W(5), .DEBOUNCE_CYC(4)) dut5 (
    .clock(clock), .rst(rst), .cs(cs5), .io_read(rd5), .io_write(wr5),
    .addr(addr5), .wdata(wdata5), .rdata(rdata5), .switches(switches5),
    .leds(leds5), .irq(irq5)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic readReg(input logic [3:0] a, output logic [31:0] data);
    cs = 1'b1; io_read = 1'b1; addr = a;
    #1;
    data = rdata;
    cs = 1'b0; io_read = 1'b0;
  endtask

  task automatic writeReg(input logic [3:0] a, input logic [31:0] data);
    cs = 1'b1; io_write = 1'b1; addr = a; wdata = data;
    stepCycle();
    cs = 1'b0; io_write = 1'b0;
  endtask

  task automatic alignTo(input int phase);
    while ((cyc % 4) != phase) stepCycle();
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    cs = v.cs; io_read = v.rd; io_write = v.wr; addr = v.addr; wdata = v.wdata;
    #1;
    checkOutput($sformatf("vec%0d rdata", idx), rdata, v.exp_rdata);
    @(posedge clock);
    #1;
    cs = 1'b0; io_read = 1'b0; io_write = 1'b0;
    checkOutput($sformatf("vec%0d leds", idx), {16'h0, leds}, {16'h0, v.exp_leds});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'h4, 32'hDEADBEEF, 32'h0000_0000, 16'hBEEF};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'h4, 32'h0,        32'h0000_BEEF, 16'hBEEF};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,        32'h0000_0000, 16'hBEEF};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        32'h0000_FFFF, 16'hBEEF};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'h8, 32'h0,        32'h0000_FFFF, 16'hBEEF};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'h8, 32'h0000_00FF, 32'h0000_0000, 16'hBEEF};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'h8, 32'h0,        32'h0000_FF00, 16'hBEEF};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'h4, 32'h0000_1234, 32'h0000_BEEF, 16'h1234};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'h7, 32'h0,        32'h0000_1234, 16'h1234};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'h4, 32'h0000_FFFF, 32'h0000_0000, 16'h1234};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'h4, 32'h0,        32'h0000_0000, 16'h1234};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 4'hC, 32'hFFFF_0001, 32'h0000_0000, 16'h1234};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 4'hC, 32'h0,        32'h0000_0001, 16'h1234};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0000_0000, 16'h1234};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 4'h8, 32'h0,        32'h0000_0000, 16'h1234};

    rst = 1'b0; cs = 1'b0; io_read = 1'b0; io_write = 1'b0; addr = 4'h0;
    wdata = 32'h0; switches = 16'hFFFF;
    cs5 = 1'b0; rd5 = 1'b0; wr5 = 1'b0; addr5 = 4'h0; wdata5 = 32'h0;
    switches5 = 5'h0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset leds", {16'h0, leds}, 32'h0);
    checkOutput("reset irq", {31'h0, irq}, 32'h0);
    checkOutput("reset rdata unselected", rdata, 32'h0);
    checkOutput("reset leds5", {27'h0, leds5}, 32'h0);

    // Release; SW must only become visible at the second tick (edge 8).
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      stepCycle();
      readReg(4'h0, d);
      checkOutput($sformatf("sw after reset edge %0d", k), d,
                  (k < 8) ? 32'h0 : 32'h0000_FFFF);
    end
    checkOutput("irq after reset accept", {31'h0, irq}, 32'h0);

    for (int i = 0; i < 15; i++) applyStimulus(i, vecs[i]);

    // All switches fall; IEN bit 0 is set so irq must follow.
    switches = 16'h0;
    repeat (12) stepCycle();
    readReg(4'h0, d);
    checkOutput("sw all low", d, 32'h0);
    readReg(4'h8, d);
    checkOutput("edge all fall", d, 32'h0000_FFFF);
    checkOutput("irq on fall", {31'h0, irq}, 32'h1);
    writeReg(4'h8, 32'hFFFF_FFFF);
    readReg(4'h8, d);
    checkOutput("edge cleared", d, 32'h0);
    checkOutput("irq lingers one cycle", {31'h0, irq}, 32'h1);
    stepCycle();
    checkOutput("irq drops", {31'h0, irq}, 32'h0);

    // 3-cycle glitch on bit 0 that falls entirely between ticks.
    alignTo(2);
    switches[0] = 1'b1;
    repeat (3) stepCycle();
    switches[0] = 1'b0;
    repeat (12) stepCycle();
    readReg(4'h0, d);
    checkOutput("glitch sw", d, 32'h0);
    readReg(4'h8, d);
    checkOutput("glitch edge", d, 32'h0);
    checkOutput("glitch irq", {31'h0, irq}, 32'h0);

    // Held rise on bit 0: samp at edge e+6, stable/EDGE at e+10, irq at e+11.
    alignTo(2);
    switches[0] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      stepCycle();
      if (k == 9) begin
        readReg(4'h0, d);
        checkOutput("held sw before accept", d, 32'h0);
      end
      if (k == 10) begin
        readReg(4'h0, d);
        checkOutput("held sw accepted", d, 32'h1);
        readReg(4'h8, d);
        checkOutput("held edge set", d, 32'h1);
        checkOutput("held irq not yet", {31'h0, irq}, 32'h0);
      end
      if (k == 11) checkOutput("held irq", {31'h0, irq}, 32'h1);
    end
    writeReg(4'h8, 32'h1);
    readReg(4'h8, d);
    checkOutput("w1c edge bit0", d, 32'h0);
    checkOutput("irq after w1c", {31'h0, irq}, 32'h1);
    stepCycle();
    checkOutput("irq falls after w1c", {31'h0, irq}, 32'h0);

    // W1C of bit 3 lands on the same edge that sets it (e+10).
    alignTo(2);
    switches[3] = 1'b1;
    repeat (9) stepCycle();
    writeReg(4'h8, 32'h8);
    readReg(4'h8, d);
    checkOutput("collision set wins", d, 32'h8);
    stepCycle();
    checkOutput("collision irq masked", {31'h0, irq}, 32'h0);
    writeReg(4'h8, 32'h8);
    readReg(4'h8, d);
    checkOutput("collision later clear", d, 32'h0);

    // Falling change on bit 0 also flags.
    switches[0] = 1'b0;
    repeat (12) stepCycle();
    readReg(4'h0, d);
    checkOutput("fall sw", d, 32'h8);
    readReg(4'h8, d);
    checkOutput("fall edge", d, 32'h1);
    checkOutput("fall irq", {31'h0, irq}, 32'h1);

    // Narrow instance: upper write bits are dropped.
    cs5 = 1'b1; wr5 = 1'b1; addr5 = 4'h4; wdata5 = 32'hFFFF_FFFF;
    stepCycle();
    cs5 = 1'b0; wr5 = 1'b0;
    checkOutput("ch5 leds", {27'h0, leds5}, 32'h0000_001F);
    cs5 = 1'b1; rd5 = 1'b1; addr5 = 4'h4;
    #1;
    checkOutput("ch5 read led", rdata5, 32'h0000_001F);
    cs5 = 1'b0; rd5 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
